// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, 1-cycle ROM, 2-entry buffer,
// branch redirect and HALT detection.
module fetch_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         head_q;
  logic [1:0]   count_q;
  logic         wr_idx;

  // Write slot is the one after the head; at count 2 it is the
  // head slot, which is only legal because it pops the same cycle.
  assign wr_idx = head_q ^ count_q[0];
  assign count  = count_q;
  assign head   = mem[head_q];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_q ^ pop;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !clear) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HALT_OP = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  localparam int EW = ADDR_W + DATA_W;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] ppc_q;
  logic              pend_q;
  logic [1:0]        count;
  logic [EW-1:0]     head;
  logic              valid;
  logic              pop;
  logic              halt_pop;
  logic              issue;
  logic              flush;
  logic              push;
  logic [2:0]        occ;

  fetch_buf #(
    .W(EW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .wdata ({ppc_q, imem_rdata}),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  always_comb begin
    valid    = (count != 2'd0) && !reset;
    pop      = valid && out_ready;
    halt_pop = pop && (head[DATA_W-1:0] == HALT_OP);
    occ      = 3'(count) + 3'(pend_q) - 3'(pop);
  end

  // Branch outranks HALT; a HALT pop freezes the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    flush   = 1'b0;
    if (reset) begin
      state_d = RUN;
      pc_d    = RESET_PC;
    end else if (branch_valid) begin
      state_d = RUN;
      pc_d    = branch_target;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_pop) begin
            state_d = HALT;
            flush   = 1'b1;
          end else begin
            issue = occ < 3'd2;
            if (issue) begin
              pc_d = pc_q + ADDR_W'(1);
            end
          end
        end
        HALT: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      ppc_q <= pc_q;
    end
  end

  assign push      = pend_q && !flush;
  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign out_valid = valid;
  assign out_instr = valid ? head[DATA_W-1:0] : '0;
  assign out_pc    = valid ? head[EW-1:DATA_W] : '0;
  assign halted    = (state_q == HALT) && !reset;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle vector table plus
// hand sequences for HALT, reset and PC wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        halted;

  logic        w_en;
  logic [7:0]  w_addr;
  logic [15:0] w_rdata;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [7:0]  w_pc;
  logic        w_halted;

  logic [15:0] rom  [256];
  logic [15:0] rom2 [256];

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halted        (halted)
  );

  instr_fetch #(
    .RESET_PC(8'hFE)
  ) u_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem_en       (w_en),
    .imem_addr     (w_addr),
    .imem_rdata    (w_rdata),
    .out_valid     (w_valid),
    .out_ready     (1'b1),
    .out_instr     (w_instr),
    .out_pc        (w_pc),
    .branch_valid  (1'b0),
    .branch_target (8'h00),
    .halted        (w_halted)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom[imem_addr];
    if (w_en) w_rdata <= rom2[w_addr];
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [7:0]  tgt;
    logic        en;
    logic [7:0]  addr;
    logic        v;
    logic [7:0]  pc;
    logic [15:0] ins;
    logic        hlt;
    logic        dz;
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  function automatic vec_t mk(
    logic rst, logic rdy, logic br, logic [7:0] tgt,
    logic en, logic [7:0] addr,
    logic v, logic [7:0] pc, logic [15:0] ins,
    logic hlt, logic dz);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.br = br; t.tgt = tgt;
    t.en = en; t.addr = addr;
    t.v = v; t.pc = pc; t.ins = ins;
    t.hlt = hlt; t.dz = dz;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic rdy, logic br, logic [7:0] tgt);
    @(negedge clk);
    reset         = r;
    out_ready     = rdy;
    branch_valid  = br;
    branch_target = tgt;
    #1;
  endtask

  task automatic restart(string tag);
    step(0, 1, 0, 8'h00);
    chk({tag, "_v1"}, 32'(out_valid), 0);
    chk({tag, "_h1"}, 32'(halted), 0);
    chk({tag, "_en1"}, 32'(imem_en), 1);
    chk({tag, "_a1"}, 32'(imem_addr), 32'h00);
    chk({tag, "_pc1"}, 32'(out_pc), 0);
    chk({tag, "_in1"}, 32'(out_instr), 0);
    step(0, 1, 0, 8'h00);
    chk({tag, "_v2"}, 32'(out_valid), 0);
    chk({tag, "_a2"}, 32'(imem_addr), 32'h01);
    step(0, 1, 0, 8'h00);
    chk({tag, "_v3"}, 32'(out_valid), 1);
    chk({tag, "_pc3"}, 32'(out_pc), 32'h00);
    chk({tag, "_in3"}, 32'(out_instr), 32'h0100);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 16'h0100 + 16'(i);
      rom2[i] = 16'h0200 + 16'(i);
    end

    //         rst rdy br tgt    en adr    v  pc     ins       h  dz
    tv[0]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 1);
    tv[1]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 1);
    tv[2]  = mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 16'h0000, 0, 1);
    tv[3]  = mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 16'h0000, 0, 0);
    tv[4]  = mk(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 16'h0100, 0, 0);
    tv[5]  = mk(0, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01, 16'h0101, 0, 0);
    tv[6]  = mk(0, 1, 0, 8'h00, 1, 8'h04, 1, 8'h02, 16'h0102, 0, 0);
    tv[7]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h03, 16'h0103, 0, 0);
    tv[8]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h03, 16'h0103, 0, 0);
    tv[9]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h03, 16'h0103, 0, 0);
    tv[10] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h03, 16'h0103, 0, 0);
    tv[11] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h03, 16'h0103, 0, 0);
    tv[12] = mk(0, 1, 0, 8'h00, 1, 8'h05, 1, 8'h03, 16'h0103, 0, 0);
    tv[13] = mk(0, 1, 0, 8'h00, 1, 8'h06, 1, 8'h04, 16'h0104, 0, 0);
    tv[14] = mk(0, 1, 0, 8'h00, 1, 8'h07, 1, 8'h05, 16'h0105, 0, 0);
    tv[15] = mk(0, 1, 0, 8'h00, 1, 8'h08, 1, 8'h06, 16'h0106, 0, 0);
    tv[16] = mk(0, 0, 1, 8'h40, 0, 8'h00, 1, 8'h07, 16'h0107, 0, 0);
    tv[17] = mk(0, 1, 0, 8'h00, 1, 8'h40, 0, 8'h00, 16'h0000, 0, 0);
    tv[18] = mk(0, 1, 0, 8'h00, 1, 8'h41, 0, 8'h00, 16'h0000, 0, 0);
    tv[19] = mk(0, 1, 0, 8'h00, 1, 8'h42, 1, 8'h40, 16'h0140, 0, 0);
    tv[20] = mk(0, 1, 0, 8'h00, 1, 8'h43, 1, 8'h41, 16'h0141, 0, 0);
    tv[21] = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 1);
    tv[22] = mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 16'h0000, 0, 1);
    tv[23] = mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 16'h0000, 0, 0);
    tv[24] = mk(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 16'h0100, 0, 0);

    for (int i = 0; i < NV; i++) begin
      step(tv[i].rst, tv[i].rdy, tv[i].br, tv[i].tgt);
      chk($sformatf("r%0d_en", i), 32'(imem_en), 32'(tv[i].en));
      if (tv[i].en)
        chk($sformatf("r%0d_addr", i), 32'(imem_addr), 32'(tv[i].addr));
      chk($sformatf("r%0d_valid", i), 32'(out_valid), 32'(tv[i].v));
      if (tv[i].v || tv[i].dz) begin
        chk($sformatf("r%0d_pc", i), 32'(out_pc), 32'(tv[i].pc));
        chk($sformatf("r%0d_ins", i), 32'(out_instr), 32'(tv[i].ins));
      end
      chk($sformatf("r%0d_halted", i), 32'(halted), 32'(tv[i].hlt));
    end

    // HALT word at PC 5, delivered once, then stopped until a branch
    rom[5] = 16'hFFFF;
    step(0, 1, 1, 8'h03);
    step(0, 1, 0, 8'h00);
    chk("h_a3", 32'(imem_addr), 32'h03);
    chk("h_en3", 32'(imem_en), 1);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("h_pc3", 32'(out_pc), 32'h03);
    step(0, 1, 0, 8'h00);
    chk("h_pc4", 32'(out_pc), 32'h04);
    step(0, 1, 0, 8'h00);
    chk("h_v5", 32'(out_valid), 1);
    chk("h_pc5", 32'(out_pc), 32'h05);
    chk("h_in5", 32'(out_instr), 32'hFFFF);
    chk("h_en5", 32'(imem_en), 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 8'h00);
      chk($sformatf("hh%0d_halted", k), 32'(halted), 1);
      chk($sformatf("hh%0d_en", k), 32'(imem_en), 0);
      chk($sformatf("hh%0d_valid", k), 32'(out_valid), 0);
    end
    step(0, 1, 1, 8'h10);
    chk("hb_halted", 32'(halted), 1);
    step(0, 1, 0, 8'h00);
    chk("hb_halted1", 32'(halted), 0);
    chk("hb_en1", 32'(imem_en), 1);
    chk("hb_a1", 32'(imem_addr), 32'h10);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("hb_v3", 32'(out_valid), 1);
    chk("hb_pc3", 32'(out_pc), 32'h10);
    chk("hb_in3", 32'(out_instr), 32'h0110);

    // Reset while halted
    step(0, 1, 1, 8'h03);
    repeat (5) step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("rh_halted", 32'(halted), 1);
    step(1, 1, 0, 8'h00);
    chk("rh_rst_halted", 32'(halted), 0);
    chk("rh_rst_en", 32'(imem_en), 0);
    chk("rh_rst_v", 32'(out_valid), 0);
    restart("rh");

    // Reset under backpressure
    repeat (4) step(0, 0, 0, 8'h00);
    chk("rb_full_en", 32'(imem_en), 0);
    chk("rb_full_v", 32'(out_valid), 1);
    step(1, 0, 0, 8'h00);
    chk("rb_rst_v", 32'(out_valid), 0);
    restart("rb");

    // PC wrap from RESET_PC 0xFE
    step(1, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("w_en1", 32'(w_en), 1);
    chk("w_a1", 32'(w_addr), 32'hFE);
    step(0, 1, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] epc;
      epc = 8'hFE + 8'(k);
      step(0, 1, 0, 8'h00);
      chk($sformatf("w%0d_v", k), 32'(w_valid), 1);
      chk($sformatf("w%0d_pc", k), 32'(w_pc), 32'(epc));
      chk($sformatf("w%0d_in", k), 32'(w_instr), 32'h0200 + 32'(epc));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
